parser_dispatch_ctrl: RTL

- Sequencing FSM for the header buffer/parser datapath in the data_processing scheduler.
- Drives the buffer's state/count inputs and gates the AXI-Stream handshake.
- Once the header is captured, issues a TCAM lookup on the parsed key and length-checks the packet.
- Then replays the captured header and streams the payload to the chosen tdest, or drains and drops the packet.

---
 rtl/parser_dispatch_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/parser_dispatch_ctrl.sv
// parser_dispatch_ctrl: header capture, TCAM lookup, length check and header replay/payload dispatch.
// Define PARSER_DISPATCH_DEFAULT_DEST_EN to forward lookup misses/timeouts to DEFAULT_DEST instead of dropping.
module parser_dispatch_ctrl #(
    parameter int AXIS_DATA_WIDTH     = 64,
    parameter int AXIS_DEST_WIDTH     = 2,
    parameter int BUFFER_DATA_WIDTH   = 192,
    parameter int COUNTER_WIDTH       = $clog2(BUFFER_DATA_WIDTH / AXIS_DATA_WIDTH + 1),
    parameter int PACKET_LENGTH_WIDTH = 16,
    parameter int MIN_PACKET_LENGTH   = 46,
    parameter int LOOKUP_TIMEOUT      = 16,
    parameter int STATE_WIDTH         = 3,
    parameter int DEFAULT_DEST        = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [STATE_WIDTH-1:0]         state,
    output logic [COUNTER_WIDTH-1:0]       count,
    input  logic [PACKET_LENGTH_WIDTH-1:0] packet_length,
    output logic                           tcam_req,
    input  logic                           tcam_rsp_valid,
    input  logic                           tcam_rsp_hit,
    input  logic [AXIS_DEST_WIDTH-1:0]     tcam_rsp_dest,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic [AXIS_DEST_WIDTH-1:0]     m_axis_tdest,
    input  logic                           m_axis_tready,
    output logic [15:0]                    drop_count
);

    localparam int HEADER_BEATS = BUFFER_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int CTL_WIDTH    = $clog2(LOOKUP_TIMEOUT + 3);
    localparam logic [COUNTER_WIDTH-1:0]       LAST_BEAT  = COUNTER_WIDTH'(HEADER_BEATS - 1);
    localparam logic [CTL_WIDTH-1:0]           REQ_AT     = CTL_WIDTH'(2);
    localparam logic [CTL_WIDTH-1:0]           TIMEOUT_AT = CTL_WIDTH'(LOOKUP_TIMEOUT + 2);
    localparam logic [PACKET_LENGTH_WIDTH-1:0] MIN_LEN    = PACKET_LENGTH_WIDTH'(MIN_PACKET_LENGTH);
`ifdef PARSER_DISPATCH_DEFAULT_DEST_EN
    localparam logic DEFAULT_EN = 1'b1;
`else
    localparam logic DEFAULT_EN = 1'b0;
`endif

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE               = STATE_WIDTH'(0),
        PARSE_DATA         = STATE_WIDTH'(1),
        CONTROL            = STATE_WIDTH'(2),
        SEND_ANALYSED_DATA = STATE_WIDTH'(3),
        SEND_REMAIN        = STATE_WIDTH'(4),
        DROP               = STATE_WIDTH'(5)
    } state_t;

    state_t                     state_q, state_d;
    logic [COUNTER_WIDTH-1:0]   count_q, count_d;
    logic [CTL_WIDTH-1:0]       ctl_q, ctl_d;
    logic                       hdr_last_q, hdr_last_d;
    logic [AXIS_DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [15:0]                drop_q, drop_d;
    logic                       drop_inc, to_drop;

    // ctl_q sequences CONTROL: 0..1 settle, REQ_AT issues the lookup, later values wait for the response
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        ctl_d         = ctl_q;
        hdr_last_d    = hdr_last_q;
        tdest_d       = tdest_q;
        drop_inc      = 1'b0;
        to_drop       = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        tcam_req      = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_d = PARSE_DATA;
                    count_d = '0;
                end
            end
            PARSE_DATA: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (count_q == LAST_BEAT) begin
                        state_d    = CONTROL;
                        count_d    = '0;
                        ctl_d      = '0;
                        hdr_last_d = s_axis_tlast;
                    end else if (s_axis_tlast) begin
                        state_d  = IDLE;
                        count_d  = '0;
                        drop_inc = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            CONTROL: begin
                ctl_d = ctl_q + 1'b1;
                if (ctl_q == REQ_AT) begin
                    to_drop  = packet_length < MIN_LEN;
                    tcam_req = !to_drop;
                end else if (ctl_q > REQ_AT) begin
                    if (tcam_rsp_valid && tcam_rsp_hit) begin
                        state_d = SEND_ANALYSED_DATA;
                        tdest_d = tcam_rsp_dest;
                    end else if (tcam_rsp_valid || ctl_q == TIMEOUT_AT) begin
                        state_d = DEFAULT_EN ? SEND_ANALYSED_DATA : state_q;
                        tdest_d = DEFAULT_EN ? AXIS_DEST_WIDTH'(DEFAULT_DEST) : tdest_q;
                        to_drop = !DEFAULT_EN;
                    end
                end
                if (to_drop) begin
                    state_d  = hdr_last_q ? IDLE : DROP;
                    drop_inc = hdr_last_q;
                end
            end
            SEND_ANALYSED_DATA: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = hdr_last_q && count_q == LAST_BEAT;
                if (m_axis_tready) begin
                    state_d = count_q == LAST_BEAT ? (hdr_last_q ? IDLE : SEND_REMAIN) : state_q;
                    count_d = count_q == LAST_BEAT ? '0 : count_q + 1'b1;
                end
            end
            SEND_REMAIN: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = s_axis_tlast;
                state_d       = s_axis_tvalid && m_axis_tready && s_axis_tlast ? IDLE : state_q;
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d  = IDLE;
                    drop_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        drop_d = drop_inc && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            ctl_q      <= '0;
            hdr_last_q <= 1'b0;
            tdest_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ctl_q      <= ctl_d;
            hdr_last_q <= hdr_last_d;
            tdest_q    <= tdest_d;
            drop_q     <= drop_d;
        end
    end

    assign state        = state_q;
    assign count        = count_q;
    assign m_axis_tdest = tdest_q;
    assign drop_count   = drop_q;

endmodule
